// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the fetch and decode stages: widths, the canonical NOP,
// opcode encodings and the fetch FSM state encoding.
package rv32_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads a fetched word, holds under stall, and falls back to
// an invalid NOP on flush or when decode drains it without a replacement.
module if_id_reg import rv32_pkg::*; #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            flush_i,
  input  logic            load_i,
  input  logic            stall_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [31:0]     instr_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_o    <= 1'b0;
      pc_o       <= '0;
      pc_plus4_o <= '0;
      instr_o    <= NOP_INSTR;
    end else if (flush_i) begin
      valid_o <= 1'b0;
      instr_o <= NOP_INSTR;
    end else if (load_i) begin
      valid_o    <= 1'b1;
      pc_o       <= pc_i;
      pc_plus4_o <= pc_i + XLEN'(4);
      instr_o    <= instr_i;
    end else if (!stall_i) begin
      // Decode consumed the entry and nothing replaces it.
      valid_o <= 1'b0;
      instr_o <= NOP_INSTR;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, single-outstanding imem request FSM with a
// one-entry skid buffer, and the IF/ID register feeding decode.
module fetch_stage import rv32_pkg::*; #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            stall_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            if_id_valid_o,
  output logic [XLEN-1:0] if_id_pc_o,
  output logic [XLEN-1:0] if_id_pc_plus4_o,
  output logic [31:0]     if_id_instr_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic [XLEN-1:0] buf_pc_q, buf_pc_d;
  logic [31:0]     buf_instr_q, buf_instr_d;

  logic            can_load;
  logic            ifid_flush, ifid_load;
  logic [XLEN-1:0] ifid_pc;
  logic [31:0]     ifid_instr;
  logic [XLEN-1:0] redirect_target;

  assign redirect_target = redirect_pc_i & ~XLEN'(3);
  assign imem_req_o      = (state_q == S_REQ) && !reset_i;
  assign imem_addr_o     = pc_q;
  assign can_load        = !if_id_valid_o || !stall_i;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    kill_d        = kill_q;
    inflight_pc_d = inflight_pc_q;
    buf_pc_d      = buf_pc_q;
    buf_instr_d   = buf_instr_q;
    ifid_flush    = 1'b0;
    ifid_load     = 1'b0;
    ifid_pc       = inflight_pc_q;
    ifid_instr    = imem_rdata_i;

    if (redirect_i) begin
      pc_d       = redirect_target;
      ifid_flush = 1'b1;
      // A request still in flight must have its response swallowed.
      if ((state_q == S_WAIT && !imem_rvalid_i) || (imem_req_o && imem_gnt_i)) begin
        state_d = S_WAIT;
        kill_d  = 1'b1;
      end else begin
        state_d = S_REQ;
        kill_d  = 1'b0;
      end
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem_gnt_i) begin
            inflight_pc_d = pc_q;
            state_d       = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            state_d = S_REQ;
            if (kill_q) begin
              kill_d = 1'b0;
            end else if (can_load) begin
              ifid_load = 1'b1;
              pc_d      = inflight_pc_q + XLEN'(4);
            end else begin
              buf_pc_d    = inflight_pc_q;
              buf_instr_d = imem_rdata_i;
              pc_d        = inflight_pc_q + XLEN'(4);
              state_d     = S_FULL;
            end
          end
        end
        S_FULL: begin
          if (!stall_i) begin
            ifid_load  = 1'b1;
            ifid_pc    = buf_pc_q;
            ifid_instr = buf_instr_q;
            state_d    = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
    end
  end

  always_ff @(posedge clk_i) begin
    inflight_pc_q <= inflight_pc_d;
    buf_pc_q      <= buf_pc_d;
    buf_instr_q   <= buf_instr_d;
  end

  if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .flush_i    (ifid_flush),
    .load_i     (ifid_load),
    .stall_i    (stall_i),
    .pc_i       (ifid_pc),
    .instr_i    (ifid_instr),
    .valid_o    (if_id_valid_o),
    .pc_o       (if_id_pc_o),
    .pc_plus4_o (if_id_pc_plus4_o),
    .instr_o    (if_id_instr_o)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: in-order fetch, stall/buffer, redirect/kill, PC wrap,
// and reset while a killed response is pending.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        stall_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        if_id_valid_o;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_pc_plus4_o;
  logic [31:0] if_id_instr_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .stall_i          (stall_i),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_gnt_i       (imem_gnt_i),
    .imem_rvalid_i    (imem_rvalid_i),
    .imem_rdata_i     (imem_rdata_i),
    .if_id_valid_o    (if_id_valid_o),
    .if_id_pc_o       (if_id_pc_o),
    .if_id_pc_plus4_o (if_id_pc_plus4_o),
    .if_id_instr_o    (if_id_instr_o)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; stall_i = 1'b0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    tick(); tick();
    chk("rst_valid", {31'b0, if_id_valid_o}, 32'd0);
    chk("rst_instr", if_id_instr_o, NOP);
    chk("rst_pc", if_id_pc_o, 32'd0);
    chk("rst_pc4", if_id_pc_plus4_o, 32'd0);
    #1 chk("rst_req", {31'b0, imem_req_o}, 32'd0);

    // 1: basic in-order fetch
    reset_i = 1'b0; imem_gnt_i = 1'b1;
    #1 chk("t1_req0", {31'b0, imem_req_o}, 32'd1);
    chk("t1_addr0", imem_addr_o, 32'h0);
    tick();
    imem_rvalid_i = 1'b1; imem_rdata_i = word(32'h0);
    #1 chk("t1_wait_req", {31'b0, imem_req_o}, 32'd0);
    tick();
    imem_rvalid_i = 1'b0;
    chk("t1_valid0", {31'b0, if_id_valid_o}, 32'd1);
    chk("t1_pc0", if_id_pc_o, 32'h0);
    chk("t1_pc4_0", if_id_pc_plus4_o, 32'h4);
    chk("t1_instr0", if_id_instr_o, word(32'h0));
    #1 chk("t1_addr4", imem_addr_o, 32'h4);
    tick();
    chk("t1_drain_valid", {31'b0, if_id_valid_o}, 32'd0);
    chk("t1_drain_instr", if_id_instr_o, NOP);
    imem_rvalid_i = 1'b1; imem_rdata_i = word(32'h4);
    tick();
    imem_rvalid_i = 1'b0;
    chk("t1_pc4", if_id_pc_o, 32'h4);
    chk("t1_pc4_4", if_id_pc_plus4_o, 32'h8);
    chk("t1_instr4", if_id_instr_o, word(32'h4));

    // 2: stall while word at 8 returns -> buffered
    stall_i = 1'b1;
    #1 chk("t2_addr8", imem_addr_o, 32'h8);
    tick();
    chk("t2_hold_pc", if_id_pc_o, 32'h4);
    chk("t2_hold_valid", {31'b0, if_id_valid_o}, 32'd1);
    imem_rvalid_i = 1'b1; imem_rdata_i = word(32'h8);
    tick();
    imem_rvalid_i = 1'b0;
    chk("t2_full_pc", if_id_pc_o, 32'h4);
    chk("t2_full_instr", if_id_instr_o, word(32'h4));
    #1 chk("t2_full_req", {31'b0, imem_req_o}, 32'd0);
    tick();
    chk("t2_full2_pc", if_id_pc_o, 32'h4);
    #1 chk("t2_full2_req", {31'b0, imem_req_o}, 32'd0);
    stall_i = 1'b0;
    tick();
    chk("t2_unbuf_pc", if_id_pc_o, 32'h8);
    chk("t2_unbuf_instr", if_id_instr_o, word(32'h8));
    chk("t2_unbuf_pc4", if_id_pc_plus4_o, 32'hC);
    #1 chk("t2_req12", {31'b0, imem_req_o}, 32'd1);
    chk("t2_addr12", imem_addr_o, 32'hC);

    // 3: redirect in S_WAIT, stale response killed
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
    tick();
    redirect_i = 1'b0;
    chk("t3_valid", {31'b0, if_id_valid_o}, 32'd0);
    chk("t3_instr", if_id_instr_o, NOP);
    imem_rvalid_i = 1'b1; imem_rdata_i = word(32'hC);
    #1 chk("t3_kill_req", {31'b0, imem_req_o}, 32'd0);
    tick();
    imem_rvalid_i = 1'b0;
    chk("t3_drop_valid", {31'b0, if_id_valid_o}, 32'd0);
    #1 chk("t3_req", {31'b0, imem_req_o}, 32'd1);
    chk("t3_addr", imem_addr_o, 32'h100);

    // 4: redirect + rvalid same cycle under stall
    tick();
    imem_rvalid_i = 1'b1; imem_rdata_i = word(32'h100);
    tick();
    imem_rvalid_i = 1'b0;
    chk("t4_pc", if_id_pc_o, 32'h100);
    stall_i = 1'b1;
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    imem_rvalid_i = 1'b1; imem_rdata_i = word(32'h104);
    tick();
    redirect_i = 1'b0; imem_rvalid_i = 1'b0;
    chk("t4_flush_valid", {31'b0, if_id_valid_o}, 32'd0);
    chk("t4_flush_instr", if_id_instr_o, NOP);
    #1 chk("t4_req", {31'b0, imem_req_o}, 32'd1);
    chk("t4_addr", imem_addr_o, 32'h200);

    // 5: PC wrap at top of address space
    stall_i = 1'b0; imem_gnt_i = 1'b0;
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0; imem_gnt_i = 1'b1;
    #1 chk("t5_addr_top", imem_addr_o, 32'hFFFF_FFFC);
    tick();
    imem_rvalid_i = 1'b1; imem_rdata_i = word(32'hFFFF_FFFC);
    tick();
    imem_rvalid_i = 1'b0;
    chk("t5_pc", if_id_pc_o, 32'hFFFF_FFFC);
    chk("t5_pc4_wrap", if_id_pc_plus4_o, 32'h0);
    #1 chk("t5_addr_wrap", imem_addr_o, 32'h0);

    // 6: reset while a killed response is pending
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h300;
    tick();
    redirect_i = 1'b0; reset_i = 1'b1;
    #1 chk("t6_req_in_rst", {31'b0, imem_req_o}, 32'd0);
    tick();
    reset_i = 1'b0; imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1; imem_rdata_i = word(32'h300);
    chk("t6_valid", {31'b0, if_id_valid_o}, 32'd0);
    chk("t6_instr", if_id_instr_o, NOP);
    chk("t6_pc", if_id_pc_o, 32'h0);
    chk("t6_pc4", if_id_pc_plus4_o, 32'h0);
    #1 chk("t6_req", {31'b0, imem_req_o}, 32'd1);
    chk("t6_addr", imem_addr_o, 32'h0);
    tick();
    imem_rvalid_i = 1'b0;
    chk("t6_late_ignored", {31'b0, if_id_valid_o}, 32'd0);
    #1 chk("t6_still_req", {31'b0, imem_req_o}, 32'd1);
    imem_gnt_i = 1'b1;
    tick();
    imem_rvalid_i = 1'b1; imem_rdata_i = word(32'h0);
    tick();
    imem_rvalid_i = 1'b0;
    chk("t6_refetch_pc", if_id_pc_o, 32'h0);
    chk("t6_refetch_instr", if_id_instr_o, word(32'h0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
